// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception-controller bus: the M-stage pipeline side (master) drives the
// victim instruction, interrupt lines and mfc0/mtc0/eret controls; the CP0
// block (slave) returns read data, EPC and the flush/redirect request.
interface cp0_exc_ctrl_if;
  logic [31:0] pc_m;
  logic [4:0]  exc_code_m;
  logic        bd_m;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        exc_req;
  logic [31:0] handler_pc;

  modport master (
    output pc_m, exc_code_m, bd_m, hwint, cp0_we, cp0_addr, cp0_wdata, eret_m,
    input  cp0_rdata, epc_out, exc_req, handler_pc
  );

  modport slave (
    input  pc_m, exc_code_m, bd_m, hwint, cp0_we, cp0_addr, cp0_wdata, eret_m,
    output cp0_rdata, epc_out, exc_req, handler_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller for the 5-stage MIPS core.
// Holds SR(12), Cause(13), EPC(14) and PRId(15). Takes interrupts and M-stage
// exceptions combinationally (exc_req), records them on the following edge.
// Optional build macro CP0_COUNT_EN adds Count(9)/Compare(11) and a timer
// interrupt merged into IP[15].
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE  = 32'h2019_0305
) (
  input logic          clk,
  input logic          reset,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  // EPC
  logic [31:0] epc_q, epc_d;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_pend_q, timer_pend_d;
`endif

  logic        int_req;
  logic        sw_req;
  logic        exc_req;
  logic        mtc0_ok;
  logic [31:0] pc_align;
  logic [31:0] epc_victim;
  logic [31:0] sr_value;
  logic [31:0] cause_value;
  logic [31:0] rdata;

  // Request decision: interrupts and exceptions are both masked under EXL
  always_comb begin
    int_req    = (|(ip_q & im_q)) & ie_q & ~exl_q;
    sw_req     = (bus.exc_code_m != 5'd0) & ~exl_q;
    exc_req    = int_req | sw_req;
    mtc0_ok    = bus.cp0_we & ~exc_req;
    // Word-align the victim PC; a delay-slot victim restarts at its branch,
    // and the subtraction is allowed to wrap below address 0.
    pc_align   = bus.pc_m & ~32'h0000_0003;
    epc_victim = bus.bd_m ? (pc_align - 32'd4) : pc_align;
  end

  // Next-state for SR/Cause/EPC; an exception drops any same-cycle mtc0/eret
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
`ifdef CP0_COUNT_EN
    ip_d      = {bus.hwint[5] | timer_pend_q, bus.hwint[4:0]};
`else
    ip_d      = bus.hwint;
`endif
    if (exc_req) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'd0 : bus.exc_code_m;
      bd_d      = bus.bd_m;
      epc_d     = epc_victim;
    end else begin
      if (mtc0_ok && (bus.cp0_addr == ADDR_SR)) begin
        im_d  = bus.cp0_wdata[15:10];
        exl_d = bus.cp0_wdata[1];
        ie_d  = bus.cp0_wdata[0];
      end
      if (mtc0_ok && (bus.cp0_addr == ADDR_EPC)) begin
        epc_d = {bus.cp0_wdata[31:2], 2'b00};
      end
      // eret is applied after an SR write in the same cycle, so EXL ends 0
      if (bus.eret_m) begin
        exl_d = 1'b0;
      end
    end
  end

`ifdef CP0_COUNT_EN
  // Free-running Count, Compare and the sticky timer pending flag
  always_comb begin
    count_d      = count_q + 32'd1;
    compare_d    = compare_q;
    timer_pend_d = timer_pend_q;
    if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_pend_d = 1'b1;
    end
    if (mtc0_ok && (bus.cp0_addr == ADDR_COUNT)) begin
      count_d = bus.cp0_wdata;
    end
    if (mtc0_ok && (bus.cp0_addr == ADDR_COMPARE)) begin
      compare_d    = bus.cp0_wdata;
      timer_pend_d = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
    end
  end
`endif

  // CP0 architectural state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // mfc0 read mux; registered values only, no write-through
  always_comb begin
    sr_value    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_value = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
    rdata       = 32'd0;
    case (bus.cp0_addr)
`ifdef CP0_COUNT_EN
      ADDR_COUNT:   rdata = count_q;
      ADDR_COMPARE: rdata = compare_q;
`endif
      ADDR_SR:      rdata = sr_value;
      ADDR_CAUSE:   rdata = cause_value;
      ADDR_EPC:     rdata = epc_q;
      ADDR_PRID:    rdata = PRID_VALUE;
      default:      rdata = 32'd0;
    endcase
  end

  assign bus.cp0_rdata  = rdata;
  assign bus.epc_out    = epc_q;
  assign bus.exc_req    = exc_req;
  assign bus.handler_pc = EXC_HANDLER;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: hand-written reset sequence, a table of
// single-cycle vectors with hand-computed register contents, then Count/
// Compare (or the absence of it) as a multi-cycle sequence.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE  = 32'h2019_0305;
  localparam int NVEC = 15;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(
    .EXC_HANDLER(EXC_HANDLER),
    .PRID_VALUE (PRID_VALUE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_epco;
    logic [31:0] exp_sr;
    logic [31:0] exp_cause;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_rdata;
  endtask

  task automatic idle();
    bus.exc_code_m = 5'd0;
    bus.bd_m       = 1'b0;
    bus.cp0_we     = 1'b0;
    bus.cp0_wdata  = 32'd0;
    bus.eret_m     = 1'b0;
  endtask

  task automatic vset(input int i, input string nm, input logic [31:0] pc, input logic [4:0] exc,
                      input logic bd, input logic [5:0] hw, input logic we, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic eret, input logic req,
                      input logic [31:0] epco, input logic [31:0] sr, input logic [31:0] cause,
                      input logic [31:0] epc);
    vecs[i].name = nm;     vecs[i].pc = pc;       vecs[i].exc = exc;
    vecs[i].bd = bd;       vecs[i].hw = hw;       vecs[i].we = we;
    vecs[i].addr = addr;   vecs[i].wdata = wdata; vecs[i].eret = eret;
    vecs[i].exp_req = req; vecs[i].exp_epco = epco;
    vecs[i].exp_sr = sr;   vecs[i].exp_cause = cause; vecs[i].exp_epc = epc;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] cnt;
    bit          found;
    errors = 0;
    checks = 0;

    //   name        pc            exc  bd hw      we addr   wdata          eret req epc_out        SR            Cause          EPC
    vset(0,  "adel",      32'h0000_2FFC, 5'd4,  0, 6'd0, 0, 5'd0,  32'h0,         0, 1, 32'h0000_0000, 32'h0000_0002, 32'h0000_0010, 32'h0000_2FFC);
    vset(1,  "nest_mask", 32'h0000_3000, 5'd12, 0, 6'd1, 0, 5'd0,  32'h0,         0, 0, 32'h0000_2FFC, 32'h0000_0002, 32'h0000_0410, 32'h0000_2FFC);
    vset(2,  "eret",      32'h0000_3004, 5'd0,  0, 6'd0, 0, 5'd0,  32'h0,         1, 0, 32'h0000_2FFC, 32'h0000_0000, 32'h0000_0010, 32'h0000_2FFC);
    vset(3,  "bd_exc",    32'h0000_3008, 5'd10, 1, 6'd0, 0, 5'd0,  32'h0,         0, 1, 32'h0000_2FFC, 32'h0000_0002, 32'h8000_0028, 32'h0000_3004);
    vset(4,  "eret2",     32'h0000_4180, 5'd0,  0, 6'd0, 0, 5'd0,  32'h0,         1, 0, 32'h0000_3004, 32'h0000_0000, 32'h8000_0028, 32'h0000_3004);
    vset(5,  "mtc0_sr",   32'h0000_3004, 5'd0,  0, 6'd0, 1, 5'd12, 32'hFFFF_07FD, 0, 0, 32'h0000_3004, 32'h0000_0401, 32'h8000_0028, 32'h0000_3004);
    vset(6,  "ip_sample", 32'h0000_3008, 5'd0,  0, 6'd1, 0, 5'd0,  32'h0,         0, 0, 32'h0000_3004, 32'h0000_0401, 32'h8000_0428, 32'h0000_3004);
    vset(7,  "int_wins",  32'h0000_5000, 5'd4,  0, 6'd1, 0, 5'd0,  32'h0,         0, 1, 32'h0000_3004, 32'h0000_0403, 32'h0000_0400, 32'h0000_5000);
    vset(8,  "eret_int",  32'h0000_4180, 5'd0,  0, 6'd0, 0, 5'd0,  32'h0,         1, 0, 32'h0000_5000, 32'h0000_0401, 32'h0000_0000, 32'h0000_5000);
    vset(9,  "we_drop",   32'h0000_6002, 5'd4,  0, 6'd0, 1, 5'd12, 32'h0000_FC00, 0, 1, 32'h0000_5000, 32'h0000_0403, 32'h0000_0010, 32'h0000_6000);
    vset(10, "we_eret",   32'h0000_4180, 5'd0,  0, 6'd0, 1, 5'd12, 32'h0000_0003, 1, 0, 32'h0000_6000, 32'h0000_0001, 32'h0000_0010, 32'h0000_6000);
    vset(11, "mtc0_epc",  32'h0000_6000, 5'd0,  0, 6'd0, 1, 5'd14, 32'h1234_5677, 0, 0, 32'h0000_6000, 32'h0000_0001, 32'h0000_0010, 32'h1234_5674);
    vset(12, "mtc0_cause",32'h0000_6004, 5'd0,  0, 6'd0, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 32'h1234_5674, 32'h0000_0001, 32'h0000_0010, 32'h1234_5674);
    vset(13, "epc_wrap",  32'h0000_0002, 5'd10, 1, 6'd0, 0, 5'd0,  32'h0,         0, 1, 32'h1234_5674, 32'h0000_0003, 32'h8000_0028, 32'hFFFF_FFFC);
    vset(14, "nest_exc",  32'h0000_4180, 5'd4,  0, 6'd1, 0, 5'd0,  32'h0,         0, 0, 32'hFFFF_FFFC, 32'h0000_0003, 32'h8000_0428, 32'hFFFF_FFFC);

    // Reset sequence: load SR/EPC, then assert reset between edges
    reset        = 1'b1;
    bus.pc_m     = 32'd0;
    bus.hwint    = 6'd0;
    bus.cp0_addr = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC03;
    @(negedge clk);
    bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_3010;
    @(posedge clk); #1;
    idle();
    read_reg(5'd12, d); check("pre_rst_sr", d, 32'h0000_FC03);
    read_reg(5'd14, d); check("pre_rst_epc", d, 32'h0000_3010);
    reset = 1'b1;
    #1;
    read_reg(5'd12, d); check("rst_sr", d, 32'h0);
    read_reg(5'd13, d); check("rst_cause", d, 32'h0);
    read_reg(5'd14, d); check("rst_epc", d, 32'h0);
    read_reg(5'd15, d); check("rst_prid", d, PRID_VALUE);
    check("rst_exc_req", {31'd0, bus.exc_req}, 32'h0);
    check("rst_epc_out", bus.epc_out, 32'h0);
    check("handler_pc", bus.handler_pc, EXC_HANDLER);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors: request checked before the edge, state after it
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.pc_m       = vecs[i].pc;
      bus.exc_code_m = vecs[i].exc;
      bus.bd_m       = vecs[i].bd;
      bus.hwint      = vecs[i].hw;
      bus.cp0_we     = vecs[i].we;
      bus.cp0_addr   = vecs[i].addr;
      bus.cp0_wdata  = vecs[i].wdata;
      bus.eret_m     = vecs[i].eret;
      #1;
      check({vecs[i].name, ".exc_req"}, {31'd0, bus.exc_req}, {31'd0, vecs[i].exp_req});
      check({vecs[i].name, ".epc_out"}, bus.epc_out, vecs[i].exp_epco);
      @(posedge clk); #1;
      idle();
      read_reg(5'd12, d); check({vecs[i].name, ".sr"}, d, vecs[i].exp_sr);
      read_reg(5'd13, d); check({vecs[i].name, ".cause"}, d, vecs[i].exp_cause);
      read_reg(5'd14, d); check({vecs[i].name, ".epc"}, d, vecs[i].exp_epc);
    end

    // Count/Compare sequence (or confirm those addresses are absent)
    @(negedge clk);
    bus.hwint  = 6'd0;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'd0;
    @(negedge clk);
    bus.cp0_addr = 5'd11; bus.cp0_wdata = 32'd5;
    @(posedge clk); #1;
    idle();
`ifdef CP0_COUNT_EN
    read_reg(5'd11, d); check("compare", d, 32'd5);
    found = 1'b0;
    cnt   = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      read_reg(5'd13, d);
      if (d[15]) begin
        found = 1'b1;
        read_reg(5'd9, cnt);
        break;
      end
    end
    check("timer_ip15", {31'd0, found}, 32'd1);
    check("timer_count", cnt, 32'd7);
`else
    found = 1'b0;
    cnt   = 32'd0;
    read_reg(5'd9, d);  check("no_count", d, 32'd0);
    read_reg(5'd11, d); check("no_compare", d, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    read_reg(5'd13, d); check("no_timer_ip", d & 32'h0000_8000, 32'd0);
`endif
    read_reg(5'd0, d);  check("addr0", d, 32'd0);
    read_reg(5'd15, d); check("prid", d, PRID_VALUE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
